// File: rtl/hilo_div_if.sv
// hilo_div_if: request/result bundle between the pipeline and the HI/LO divider.
// master = pipeline side, slave = divider side.
interface hilo_div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  stall_o, ready_o, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output stall_o, ready_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div.sv
// hilo_div: restoring radix-2 divider, remainder -> HI, quotient -> LO; signed mode under DIV_SIGNED_EN.
// Fixed latency 33 cycles (2 on a zero divisor); holds the pipeline through stall_o, result is a one-cycle pulse.
module hilo_div (
  input  logic     clk,
  input  logic     rst,
  hilo_div_if.slave div
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [64:0] rq;   // [64:32] partial remainder, [31:0] dividend bits out / quotient bits in
  logic [31:0] dvs;
  logic [31:0] hi_q, lo_q;
  logic        accept, last;
  logic [31:0] mag_a, mag_b;
  logic [33:0] trial;
  logic        ge;
  logic [32:0] rem_nxt;
  logic [64:0] rq_step;
  logic [31:0] quo, rem;

  assign accept = (state == FREE) && div.start_i && !div.annul_i;
  assign last   = (cnt == 6'd31);

`ifdef DIV_SIGNED_EN
  logic sgn_a, sgn_b, neg_q, neg_r;
  assign sgn_a = div.signed_div_i & div.opdata1_i[31];
  assign sgn_b = div.signed_div_i & div.opdata2_i[31];
  assign mag_a = sgn_a ? -div.opdata1_i : div.opdata1_i;
  assign mag_b = sgn_b ? -div.opdata2_i : div.opdata2_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
    end
  end
`else
  logic signed_unused;
  assign signed_unused = div.signed_div_i;
  assign mag_a = div.opdata1_i;
  assign mag_b = div.opdata2_i;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign trial   = {rq[64:32], rq[31]};
  assign ge      = trial >= {2'b00, dvs};
  assign rem_nxt = ge ? 33'(trial - {2'b00, dvs}) : trial[32:0];
  assign rq_step = {rem_nxt, rq[30:0], ge};

  always_comb begin
    quo = rq_step[31:0];
    rem = rq_step[63:32];
    if (state == BYZERO) begin
      quo = 32'hFFFF_FFFF;
      rem = rq[31:0];
    end
`ifdef DIV_SIGNED_EN
    // Negating the dividend magnitude also restores the original dividend on the zero-divisor path.
    if (neg_q && state == ON) quo = -quo;
    if (neg_r) rem = -rem;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE:   if (accept) state_nxt = (div.opdata2_i == 32'd0) ? BYZERO : ON;
      BYZERO: state_nxt = div.annul_i ? FREE : END;
      ON: begin
        if (div.annul_i) state_nxt = FREE;
        else if (last)   state_nxt = END;
      end
      END:    state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 6'd0;
      rq   <= 65'd0;
      dvs  <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      case (state)
        FREE: if (accept) begin
          cnt <= 6'd0;
          rq  <= {33'd0, mag_a};
          dvs <= mag_b;
        end
        ON: if (!div.annul_i) begin
          rq  <= rq_step;
          cnt <= cnt + 6'd1;
          if (last) begin
            hi_q <= rem;
            lo_q <= quo;
          end
        end
        BYZERO: if (!div.annul_i) begin
          hi_q <= rem;
          lo_q <= quo;
        end
        default: ;
      endcase
    end
  end

  assign div.stall_o = accept || (!rst && (state == BYZERO || state == ON));
  assign div.ready_o = (state == END);
  assign div.whilo_o = (state == END);
  assign div.hi_o    = hi_q;
  assign div.lo_o    = lo_q;
endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: directed and randomized divides checked against a plain-arithmetic reference.
// Cycle k runs from rising edge k to k+1; inputs change 1ns after the edge, outputs are sampled 3ns after.
module tb_hilo_div;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errs = 0;
  logic [31:0] last_hi, last_lo;

  hilo_div_if bus();
  hilo_div dut (.clk(clk), .rst(rst), .div(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic quiet(input int n, output int pulses);
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      #2;
      if (bus.ready_o || bus.whilo_o) pulses++;
      tick();
    end
  endtask

  // Starts a divide in the current cycle and follows it to its result pulse.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input bit hold);
    logic [31:0] eq, er;
    int lat, rdy, stalls;
    ref_div(a, b, sg, eq, er);
    lat    = (b == 32'd0) ? 2 : 33;
    rdy    = -1;
    stalls = 0;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sg;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    for (int c = 0; c <= 40 && rdy < 0; c++) begin
      if (c > 0) begin
        bus.start_i      = hold;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
      #2;
      if (bus.stall_o) stalls++;
      if (bus.ready_o) begin
        rdy = c;
        chk({tag, "_whilo"}, bus.whilo_o, 1'b1);
        chk({tag, "_stall_end"}, bus.stall_o, 1'b0);
        chk({tag, "_lo"}, bus.lo_o, eq);
        chk({tag, "_hi"}, bus.hi_o, er);
      end else if (bus.whilo_o) begin
        chk({tag, "_whilo_early"}, bus.whilo_o, 1'b0);
      end
      tick();
    end
    chk({tag, "_latency"}, rdy, lat);
    chk({tag, "_stall_cycles"}, stalls, lat);
    last_hi = er;
    last_lo = eq;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [31:0] a, b;
    logic sg;
    bit hold;

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    #2;
    chk("rst_ready", bus.ready_o, 1'b0);
    chk("rst_whilo", bus.whilo_o, 1'b0);
    chk("rst_hi", bus.hi_o, 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    chk("rst_stall", bus.stall_o, 1'b0);
    bus.start_i = 1'b1;
    #1;
    chk("rst_stall_start", bus.stall_o, 1'b1);
    bus.start_i = 1'b0;
    tick();
    rst     = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;

    // start together with annul is not accepted
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    #2;
    chk("annul_start_stall", bus.stall_o, 1'b0);
    tick();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #2;
    chk("annul_start_idle", bus.stall_o, 1'b0);
    tick();

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    run_div("div_by_zero", 32'd5, 32'd0, 1'b0, 1'b0);
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);

    // annul in the middle of a divide
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    quiet(9, pulses);
    bus.annul_i = 1'b1;
    #2;
    chk("annul_stall_c10", bus.stall_o, 1'b1);
    if (bus.ready_o || bus.whilo_o) pulses++;
    tick();
    bus.annul_i = 1'b0;
    #2;
    chk("annul_free_c11", bus.stall_o, 1'b0);
    chk("annul_hi_hold", bus.hi_o, last_hi);
    chk("annul_lo_hold", bus.lo_o, last_lo);
    if (bus.ready_o || bus.whilo_o) pulses++;
    chk("annul_no_pulse", pulses, 0);
    tick();
    run_div("after_annul", 32'd1000, 32'd33, 1'b0, 1'b0);

    // reset in the middle of a divide
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("midrst_ready", bus.ready_o, 1'b0);
    chk("midrst_whilo", bus.whilo_o, 1'b0);
    chk("midrst_hi", bus.hi_o, 32'd0);
    chk("midrst_lo", bus.lo_o, 32'd0);
    chk("midrst_stall", bus.stall_o, 1'b0);
    tick();
    quiet(40, pulses);
    chk("midrst_no_pulse", pulses, 0);
    last_hi = 32'd0;
    last_lo = 32'd0;

    // start held through END: exactly one result, next divide begins the cycle after
    run_div("hold", 32'd1000, 32'd10, 1'b0, 1'b1);
    run_div("after_hold", 32'd77, 32'd5, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      sg   = 1'($urandom_range(0, 1));
      hold = (i < 29) && ($urandom_range(0, 3) == 0);
      run_div("rand", a, b, sg, hold);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
